data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-master arbiter in front of the sectioned data memory manager. It shares the single data memory port between the CPU load/store unit (master 0) and the DMA/image loader (master 1). It accepts at most one access per cycle and steers the one-cycle-latency read data back to the master that issued the read. It supports locked bursts with a starvation timeout and flags accesses to the unpopulated section.

## Interface
Parameters:
- LOCK_MAX, 64: maximum consecutive cycles one master may hold a lock before it is forcibly released.
- ADDR_W, 32: address width. Bits [17:16] select the section.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- m_req_i[1:0]  in  2  per-master request, held until granted.
- m_we_i[1:0]  in  2  per-master write enable (1 = write, 0 = read).
- m_lock_i[1:0]  in  2  per-master lock request for bursts.
- m0_addr_i, m1_addr_i  in  ADDR_W  byte/word address per master.
- m0_wdata_i, m1_wdata_i  in  32  write data per master.
- m_gnt_o[1:0]  out  2  combinational, one-hot or zero; the access is accepted in the cycle where req=1 and gnt=1.
- m_rvalid_o[1:0]  out  2  registered read-data valid, one cycle after the read is granted.
- m_rdata_o  out  32  registered read data, shared by both masters and qualified by m_rvalid_o.
- m_err_o[1:0]  out  2  registered; pulses with the response slot of an access to section 2'b11.
- mem_addr_o  out  ADDR_W  to the memory manager's address_i.
- mem_data_o  out  32  to the memory manager's data_i.
- mem_wren_o  out  1  to the memory manager's wren_i.
- mem_q_i  in  32  from the memory manager's data_o; valid one cycle after the address.

## Operation
- FSM states:
  - ARB: the winner is chosen among the requesting masters.
  - LOCK0 / LOCK1: only the owner can be granted; the other master's requests are ignored.
- Transitions:
  - ARB→LOCKk when master k is granted with m_lock_i[k]=1.
  - LOCKk→ARB when:
    - master k is granted with m_lock_i[k]=0, or
    - master k has req=0 and lock=0 in any cycle, or
    - lock_cnt reaches LOCK_MAX-1.
- lock_cnt:
  - Cleared on entry to LOCKk.
  - Increments every cycle spent in LOCKk, whether or not k accesses.
  - Saturating behaviour is not needed, because the state exits at LOCK_MAX-1.
- After a timeout exit, the timed-out master loses the next ARB decision if the other master is requesting.
- Arbitration in ARB: see Configuration. With a single requester, that requester always wins.
- Granted access:
  - mem_addr_o/mem_data_o come from the winner.
  - mem_wren_o = winner's we, unless section==2'b11, in which case it is 0.
  - With no grant: mem_addr_o holds the last value, mem_data_o=0, mem_wren_o=0.
- Response stage (registered):
  - Records owner, is_read and is_bad.
  - Next cycle, for a read: m_rvalid_o[owner]=1 and m_rdata_o=mem_q_i, or 0 if is_bad.
  - Next cycle, for any bad access: m_err_o[owner]=1.
  - Writes produce no rvalid.
- Back-to-back accesses are allowed every cycle. Response ordering equals grant ordering.

## Timing
- Reset values (asynchronous, applied immediately):
  - state=ARB, lock_cnt=0, rr_last=1 (master 0 favoured first).
  - m_rvalid_o=0, m_err_o=0, m_rdata_o=0.
  - mem_wren_o=0, mem_addr_o=0.
- Read latency: grant in cycle N → m_rvalid_o/m_rdata_o in cycle N+1.
- Write takes effect at the memory on the edge ending cycle N.
- gnt is combinational from req/state. Masters must not make req depend combinationally on gnt.
- Both masters requesting in the same cycle: exactly one gnt. The loser keeps req asserted.
- Reset mid-read: the pending rvalid is dropped and is not reissued.
- Lock timeout in the same cycle as an owner access: that access is still granted, and ARB takes effect next cycle.

## Configuration
- DATA_ARB_ROUND_ROBIN_EN:
  - Defined: ARB grants the master other than rr_last when both request. rr_last updates on every grant.
  - Undefined: fixed priority, master 0 always wins in ARB. rr_last is still used for the post-timeout penalty only.
- Lock/timeout logic is unaffected by the macro.

## Structure
- Package data_arb_pkg:
  - arb_state_t enum (ARB, LOCK0, LOCK1).
  - SECTION_LSB=16, SECTION_W=2, BAD_SECTION=2'b11.
  - A resp_t struct {owner, is_read, is_bad}.
- One sub-module, data_arb_pick: pure combinational two-way pick (req, rr_last, mode → one-hot gnt), reused for ARB decisions. Everything else is in the top.

## Test plan
- Reset: assert RST_n=0 mid-stream. All outputs zero immediately, state ARB; the first grant after release with both requesting goes to master 0.
- Single read: m0 reads 0x0000_0010 while mem_q_i=0xDEAD_BEEF next cycle. m_gnt_o=01 in cycle N; m_rvalid_o=01 with m_rdata_o=0xDEAD_BEEF in N+1.
- Contention: both request continuously.
  - With DATA_ARB_ROUND_ROBIN_EN: grants alternate 01,10,01,10.
  - Without it: 01 every cycle.
- Lock burst: m1 is granted with lock=1 and m0 requesting for 4 cycles. m1 gets 4 consecutive grants; m0 is granted the cycle after m1 drops lock.
- Timeout: LOCK_MAX=8, m1 holds lock and req forever. The FSM returns to ARB after 8 cycles and m0 is granted next.
- Bad section:
  - m0 writes 0x0003_0004: mem_wren_o=0, m_err_o=01 next cycle.
  - m0 reads 0x0003_0004: rvalid=01, rdata=0, err=01.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-master data memory arbiter.
package data_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int SECTION_LSB = 16;
  localparam int SECTION_W   = 2;
  localparam logic [SECTION_W-1:0] BAD_SECTION = 2'b11;

  typedef struct packed {
    logic owner;
    logic is_read;
    logic is_bad;
  } resp_t;

  function automatic logic is_bad_section(input logic [SECTION_W-1:0] sec);
    return sec == BAD_SECTION;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_pick.sv
// Combinational two-way pick: single requester always wins; on contention
// mode=1 picks the master other than rr_last, mode=0 picks master 0.
module data_arb_pick (
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       mode,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (mode && !rr_last) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter sharing the data memory port, with locked bursts and a
// lock timeout. Define DATA_ARB_ROUND_ROBIN_EN for round-robin contention.
module data_mem_arbiter
  import data_arb_pkg::*;
#(
  parameter int LOCK_MAX = 64,
  parameter int ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [1:0]        m_req_i,
  input  logic [1:0]        m_we_i,
  input  logic [1:0]        m_lock_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m0_wdata_i,
  input  logic [31:0]       m1_wdata_i,
  output logic [1:0]        m_gnt_o,
  output logic [1:0]        m_rvalid_o,
  output logic [31:0]       m_rdata_o,
  output logic [1:0]        m_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              mem_wren_o,
  input  logic [31:0]       mem_q_i
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  function automatic logic [1:0] owner_mask(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

  arb_state_t        state;
  logic [CNT_W-1:0]  lock_cnt;
  logic              rr_last;
  logic              pick_mode;
  logic [1:0]        pick_gnt;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              winner;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic              win_bad;
  logic              owner_idx;
  logic              lock_timeout;
  logic              lock_drop;
  logic [ADDR_W-1:0] addr_hold;
  resp_t             resp_p1;
  logic              vld_p1;

`ifdef DATA_ARB_ROUND_ROBIN_EN
  assign pick_mode = 1'b1;
`else
  // Fixed priority, except the first decision after a timeout penalises the
  // master that timed out (recorded in rr_last).
  logic penalty;
  assign pick_mode = penalty;
`endif

  data_arb_pick u_pick (
    .req     (m_req_i),
    .rr_last (rr_last),
    .mode    (pick_mode),
    .gnt     (pick_gnt)
  );

  always_comb begin
    gnt = 2'b00;
    if (RST_n) begin
      case (state)
        ARB:     gnt = pick_gnt;
        LOCK0:   gnt = {1'b0, m_req_i[0]};
        LOCK1:   gnt = {m_req_i[1], 1'b0};
        default: gnt = 2'b00;
      endcase
    end
  end

  assign m_gnt_o  = gnt;
  assign any_gnt  = |gnt;
  assign winner   = gnt[1];
  assign win_addr = winner ? m1_addr_i : m0_addr_i;
  assign win_we   = m_we_i[winner];
  assign win_bad  = is_bad_section(win_addr[SECTION_LSB +: SECTION_W]);

  assign mem_addr_o = any_gnt ? win_addr : addr_hold;
  assign mem_data_o = any_gnt ? (winner ? m1_wdata_i : m0_wdata_i) : 32'd0;
  assign mem_wren_o = any_gnt & win_we & ~win_bad;

  assign owner_idx    = (state == LOCK1);
  assign lock_timeout = (state != ARB) && (lock_cnt == CNT_W'(LOCK_MAX - 1));
  assign lock_drop    = (state != ARB) && !m_lock_i[owner_idx];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= ARB;
      lock_cnt <= '0;
    end else if (state == ARB) begin
      lock_cnt <= '0;
      if (any_gnt && m_lock_i[winner])
        state <= winner ? LOCK1 : LOCK0;
    end else begin
      // The owner's access in the timeout cycle is still granted above.
      lock_cnt <= lock_cnt + 1'b1;
      if (lock_timeout || lock_drop)
        state <= ARB;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rr_last <= 1'b1;
    end else if (lock_timeout) begin
      rr_last <= owner_idx;
`ifdef DATA_ARB_ROUND_ROBIN_EN
    end else if (any_gnt) begin
      rr_last <= winner;
`endif
    end
  end

`ifndef DATA_ARB_ROUND_ROBIN_EN
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)
      penalty <= 1'b0;
    else if (lock_timeout)
      penalty <= 1'b1;
    else if (state == ARB && any_gnt)
      penalty <= 1'b0;
  end
`endif

  // Stage p0 -> p1: remember who owns the response slot of this access.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      vld_p1    <= 1'b0;
      resp_p1   <= '0;
      addr_hold <= '0;
    end else begin
      vld_p1  <= any_gnt;
      resp_p1 <= '{owner: winner, is_read: ~win_we, is_bad: win_bad};
      if (any_gnt)
        addr_hold <= win_addr;
    end
  end

  assign m_rvalid_o = (vld_p1 && resp_p1.is_read) ? owner_mask(resp_p1.owner) : 2'b00;
  assign m_err_o    = (vld_p1 && resp_p1.is_bad)  ? owner_mask(resp_p1.owner) : 2'b00;
  assign m_rdata_o  = (vld_p1 && resp_p1.is_read && !resp_p1.is_bad) ? mem_q_i : 32'd0;

endmodule
